// File: rtl/board_mem_arbiter.sv
// Purpose: shares the single board BRAM port among renderer, generation updater and cell editor.
// Latency: BRAM mux is combinational; updater read data appears READ_LATENCY cycles after grant.
// Backpressure: updater holds its request until granted; an edit request while busy is dropped.
module board_mem_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int LOG_MAX_ADDR = 15,
    parameter int READ_LATENCY = 2,
    localparam int LOG_WORD_SIZE = $clog2(WORD_SIZE)
) (
    input  logic                     clk_130mhz,
    input  logic                     rst_n_in,
    input  logic                     render_done_in,
    input  logic [LOG_MAX_ADDR-1:0]  render_addr_in,
    output logic [WORD_SIZE-1:0]     render_data_out,
    input  logic                     upd_req_in,
    input  logic                     upd_we_in,
    input  logic [LOG_MAX_ADDR-1:0]  upd_addr_in,
    input  logic [WORD_SIZE-1:0]     upd_wdata_in,
    output logic                     upd_gnt_out,
    output logic                     upd_rvalid_out,
    output logic [WORD_SIZE-1:0]     upd_rdata_out,
    input  logic                     edit_req_in,
    input  logic [LOG_MAX_ADDR-1:0]  edit_addr_in,
    input  logic [LOG_WORD_SIZE-1:0] edit_bit_in,
    output logic                     edit_busy_out,
    output logic [LOG_MAX_ADDR-1:0]  mem_addr_out,
    output logic                     mem_we_out,
    output logic [WORD_SIZE-1:0]     mem_wdata_out,
    input  logic [WORD_SIZE-1:0]     mem_rdata_in
);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, EDIT_RD, EDIT_WAIT, EDIT_WR} state_t;

    state_t                   r_state;
    logic                     r_pend;
    logic [LOG_MAX_ADDR-1:0]  r_edit_addr;
    logic [LOG_WORD_SIZE-1:0] r_edit_bit;
    logic [WORD_SIZE-1:0]     r_word;
    logic [CNT_W-1:0]         r_cnt;
    logic [READ_LATENCY-1:0]  r_tag;

    logic                     w_edit_take;
    logic                     w_edit_pend;
    logic                     w_upd_gnt;
    logic [WORD_SIZE-1:0]     w_mask;

    // A new edit is accepted only while none is pending; it wins over the updater the same cycle.
    assign w_edit_take = edit_req_in & ~r_pend;
    assign w_edit_pend = r_pend | w_edit_take;
    assign w_upd_gnt   = rst_n_in & render_done_in & (r_state == IDLE) & ~w_edit_pend & upd_req_in;

    assign render_data_out = mem_rdata_in;
    assign upd_gnt_out     = w_upd_gnt;
    assign edit_busy_out   = r_pend;
    assign upd_rvalid_out  = r_tag[READ_LATENCY-1];
    assign upd_rdata_out   = r_tag[READ_LATENCY-1] ? mem_rdata_in : '0;

    // Cell index decode, MSB-first: cell 0 is the top bit of the word.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            w_mask[i] = (r_edit_bit == LOG_WORD_SIZE'(WORD_SIZE - 1 - i));
        end
    end

    // BRAM port mux: renderer owns the port whenever it is not blanking.
    always_comb begin
        mem_addr_out  = render_addr_in;
        mem_we_out    = 1'b0;
        mem_wdata_out = upd_wdata_in;
        if (render_done_in) begin
            case (r_state)
                IDLE: begin
                    if (w_upd_gnt) begin
                        mem_addr_out = upd_addr_in;
                        mem_we_out   = upd_we_in;
                    end
                end
                EDIT_RD, EDIT_WAIT: begin
                    mem_addr_out = r_edit_addr;
                end
                EDIT_WR: begin
                    mem_addr_out  = r_edit_addr;
                    mem_we_out    = rst_n_in;
                    mem_wdata_out = r_word;
                end
                default: begin
                    mem_addr_out = render_addr_in;
                end
            endcase
        end
    end

    // Edit latch and read-modify-write sequencer; abandoned (pending kept) if blanking ends.
    always_ff @(posedge clk_130mhz) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_pend      <= 1'b0;
            r_edit_addr <= '0;
            r_edit_bit  <= '0;
            r_word      <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_edit_take) begin
                r_pend      <= 1'b1;
                r_edit_addr <= edit_addr_in;
                r_edit_bit  <= edit_bit_in;
            end
            if (!render_done_in) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_edit_pend) r_state <= EDIT_RD;
                    end
                    EDIT_RD: begin
                        r_cnt   <= CNT_W'(READ_LATENCY - 1);
                        r_state <= EDIT_WAIT;
                    end
                    EDIT_WAIT: begin
                        if (r_cnt == '0) begin
                            r_word  <= mem_rdata_in ^ w_mask;
                            r_state <= EDIT_WR;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    EDIT_WR: begin
                        r_pend  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Tag pipe marks granted updater reads so their data is flagged READ_LATENCY cycles later.
    always_ff @(posedge clk_130mhz) begin
        if (!rst_n_in) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_upd_gnt & ~upd_we_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end
endmodule

// File: tb/tb_board_mem_arbiter.sv
// Purpose: directed bench for board_mem_arbiter with a BRAM model and write/read scoreboards.
// Latency: expected BRAM writes and updater read data are tagged with the cycle they must appear.
// Backpressure: updater requests are held until granted, bounded by a cycle budget.
module tb_board_mem_arbiter;
    localparam int WS = 32;
    localparam int LA = 15;
    localparam int RL = 2;
    localparam int LW = $clog2(WS);

    typedef struct {
        int          cyc;
        logic [LA-1:0] addr;
        logic [WS-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n_in;
    logic          render_done_in;
    logic [LA-1:0] render_addr_in;
    logic [WS-1:0] render_data_out;
    logic          upd_req_in, upd_we_in;
    logic [LA-1:0] upd_addr_in;
    logic [WS-1:0] upd_wdata_in;
    logic          upd_gnt_out, upd_rvalid_out;
    logic [WS-1:0] upd_rdata_out;
    logic          edit_req_in;
    logic [LA-1:0] edit_addr_in;
    logic [LW-1:0] edit_bit_in;
    logic          edit_busy_out;
    logic [LA-1:0] mem_addr_out;
    logic          mem_we_out;
    logic [WS-1:0] mem_wdata_out;
    logic [WS-1:0] mem_rdata_in;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q_wr[$];
    exp_t q_rd[$];

    logic [WS-1:0] bram [0:(1<<LA)-1];
    logic [WS-1:0] r_p1;

    board_mem_arbiter #(.WORD_SIZE(WS), .LOG_MAX_ADDR(LA), .READ_LATENCY(RL)) dut (
        .clk_130mhz(clk), .rst_n_in(rst_n_in),
        .render_done_in(render_done_in), .render_addr_in(render_addr_in),
        .render_data_out(render_data_out),
        .upd_req_in(upd_req_in), .upd_we_in(upd_we_in), .upd_addr_in(upd_addr_in),
        .upd_wdata_in(upd_wdata_in), .upd_gnt_out(upd_gnt_out),
        .upd_rvalid_out(upd_rvalid_out), .upd_rdata_out(upd_rdata_out),
        .edit_req_in(edit_req_in), .edit_addr_in(edit_addr_in), .edit_bit_in(edit_bit_in),
        .edit_busy_out(edit_busy_out),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
        .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: two-cycle registered read, synchronous write.
    always @(posedge clk) begin
        if (mem_we_out) bram[mem_addr_out] <= mem_wdata_out;
        r_p1         <= bram[mem_addr_out];
        mem_rdata_in <= r_p1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT writes the BRAM or returns updater data.
    always @(negedge clk) begin
        if (rst_n_in === 1'b1) begin
            if (mem_we_out) begin
                if (q_wr.size() == 0) chk("unexpected_write", {17'd0, mem_addr_out, mem_wdata_out}, 64'd0);
                else begin
                    exp_t e;
                    e = q_wr.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wr_addr", 64'(mem_addr_out), 64'(e.addr));
                    chk("wr_data", 64'(mem_wdata_out), 64'(e.data));
                end
            end
            if (upd_rvalid_out) begin
                if (q_rd.size() == 0) chk("unexpected_rvalid", 64'(upd_rdata_out), 64'd0);
                else begin
                    exp_t e;
                    e = q_rd.pop_front();
                    chk("rd_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rd_data", 64'(upd_rdata_out), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_access(input logic we, input logic [LA-1:0] a, input logic [WS-1:0] d,
                              input logic [WS-1:0] exp_data);
        bit got = 0;
        upd_req_in = 1'b1; upd_we_in = we; upd_addr_in = a; upd_wdata_in = d;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (upd_gnt_out) begin
                got = 1;
                if (we) q_wr.push_back('{cyc, a, d});
                else    q_rd.push_back('{cyc + RL, a, exp_data});
            end
            tick();
        end
        upd_req_in = 1'b0;
        chk("upd_gnt_seen", 64'(got), 64'd1);
    endtask

    task automatic edit_pulse(input logic [LA-1:0] a, input logic [LW-1:0] b);
        edit_req_in = 1'b1; edit_addr_in = a; edit_bit_in = b;
    endtask

    initial begin
        rst_n_in = 1'b0; render_done_in = 1'b1; render_addr_in = '0;
        upd_req_in = 1'b0; upd_we_in = 1'b0; upd_addr_in = '0; upd_wdata_in = '0;
        edit_req_in = 1'b0; edit_addr_in = '0; edit_bit_in = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(edit_busy_out), 64'd0);
        chk("rst_we", 64'(mem_we_out), 64'd0);
        chk("rst_gnt", 64'(upd_gnt_out), 64'd0);
        chk("rst_rvalid", 64'(upd_rvalid_out), 64'd0);
        chk("rst_rdata", 64'(upd_rdata_out), 64'd0);
        rst_n_in = 1'b1;
        tick();

        // Renderer owns the port during active video even with an updater request.
        render_done_in = 1'b0; render_addr_in = 15'h012;
        upd_req_in = 1'b1; upd_we_in = 1'b1; upd_addr_in = 15'h100; upd_wdata_in = 32'h55555555;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("render_addr", 64'(mem_addr_out), 64'h012);
            chk("render_we", 64'(mem_we_out), 64'd0);
            chk("render_gnt", 64'(upd_gnt_out), 64'd0);
            tick();
        end
        upd_req_in = 1'b0; render_done_in = 1'b1;
        tick();

        // Preload words through the updater, then read one back.
        upd_access(1'b1, 15'h100, 32'hDEADBEEF, '0);
        upd_access(1'b1, 15'h040, 32'h00000000, '0);
        upd_access(1'b1, 15'h041, 32'h00000001, '0);
        upd_access(1'b1, 15'h050, 32'hF0F0F0F0, '0);
        upd_access(1'b1, 15'h060, 32'hAAAAAAAA, '0);
        upd_access(1'b0, 15'h100, '0, 32'hDEADBEEF);
        repeat (3) tick();

        // Edit: read at c1, write at c4, busy low at c5.
        begin
            int c0;
            c0 = cyc;
            edit_pulse(15'h040, 5'd3);
            q_wr.push_back('{c0 + 4, 15'h040, 32'h10000000});
            for (int k = 0; k <= 5; k++) begin
                #1;
                chk("t3_busy", 64'(edit_busy_out), 64'(k >= 1 && k <= 4));
                if (k == 1) begin
                    chk("t3_rd_addr", 64'(mem_addr_out), 64'h040);
                    chk("t3_rd_we", 64'(mem_we_out), 64'd0);
                end
                tick();
                if (k == 0) edit_req_in = 1'b0;
            end
        end
        repeat (2) tick();

        // Edit and updater request together: the edit finishes first, grant the cycle after.
        begin
            int c0;
            c0 = cyc;
            edit_pulse(15'h041, 5'd0);
            q_wr.push_back('{c0 + 4, 15'h041, 32'h80000001});
            upd_req_in = 1'b1; upd_we_in = 1'b0; upd_addr_in = 15'h100;
            for (int k = 0; k <= 5; k++) begin
                #1;
                chk("t4_gnt", 64'(upd_gnt_out), 64'(k == 5));
                if (k == 5) q_rd.push_back('{cyc + RL, 15'h100, 32'hDEADBEEF});
                tick();
                if (k == 0) edit_req_in = 1'b0;
            end
            upd_req_in = 1'b0;
        end
        repeat (3) tick();

        // Blanking ends during EDIT_WAIT: no write, edit resumes in the next blanking.
        begin
            int c0;
            c0 = cyc;
            edit_pulse(15'h050, 5'd31);
            for (int k = 0; k <= 12; k++) begin
                if (k == 2) render_done_in = 1'b0;
                if (k == 7) begin
                    render_done_in = 1'b1;
                    q_wr.push_back('{cyc + 4, 15'h050, 32'hF0F0F0F1});
                end
                #1;
                chk("t5_busy", 64'(edit_busy_out), 64'(k >= 1 && k <= 11));
                if (k >= 2 && k <= 6) chk("t5_no_we", 64'(mem_we_out), 64'd0);
                tick();
                if (k == 0) edit_req_in = 1'b0;
            end
            if (cyc < c0) chk("t5_cycle_order", 64'(cyc), 64'(c0));
        end
        repeat (2) tick();

        // Reset during EDIT_WAIT discards the edit.
        edit_pulse(15'h060, 5'd4);
        for (int k = 0; k <= 4; k++) begin
            if (k == 2) rst_n_in = 1'b0;
            if (k == 3) rst_n_in = 1'b1;
            #1;
            if (k == 3) begin
                chk("t6_busy", 64'(edit_busy_out), 64'd0);
                chk("t6_we", 64'(mem_we_out), 64'd0);
            end
            tick();
            if (k == 0) edit_req_in = 1'b0;
        end

        // Read back edited and untouched words.
        upd_access(1'b0, 15'h040, '0, 32'h10000000);
        upd_access(1'b0, 15'h041, '0, 32'h80000001);
        upd_access(1'b0, 15'h050, '0, 32'hF0F0F0F1);
        upd_access(1'b0, 15'h060, '0, 32'hAAAAAAAA);

        for (int k = 0; k < 20 && (q_wr.size() != 0 || q_rd.size() != 0); k++) tick();
        chk("wr_queue_drained", 64'(q_wr.size()), 64'd0);
        chk("rd_queue_drained", 64'(q_rd.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
